seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table and the scan FSM state type.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [SEG_W-1:0] M_A = SEG_W'(1 << SEG_A);
  localparam logic [SEG_W-1:0] M_B = SEG_W'(1 << SEG_B);
  localparam logic [SEG_W-1:0] M_C = SEG_W'(1 << SEG_C);
  localparam logic [SEG_W-1:0] M_D = SEG_W'(1 << SEG_D);
  localparam logic [SEG_W-1:0] M_E = SEG_W'(1 << SEG_E);
  localparam logic [SEG_W-1:0] M_F = SEG_W'(1 << SEG_F);
  localparam logic [SEG_W-1:0] M_G = SEG_W'(1 << SEG_G);

  // Active-high glyphs, entry 15 first so that index n selects glyph n.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    M_A | M_E | M_F | M_G,                     // F
    M_A | M_D | M_E | M_F | M_G,               // E
    M_B | M_C | M_D | M_E | M_G,               // d
    M_A | M_D | M_E | M_F,                     // C
    M_C | M_D | M_E | M_F | M_G,               // b
    M_A | M_B | M_C | M_E | M_F | M_G,         // A
    M_A | M_B | M_C | M_D | M_F | M_G,         // 9
    M_A | M_B | M_C | M_D | M_E | M_F | M_G,   // 8
    M_A | M_B | M_C,                           // 7
    M_A | M_C | M_D | M_E | M_F | M_G,         // 6
    M_A | M_C | M_D | M_F | M_G,               // 5
    M_B | M_C | M_F | M_G,                     // 4
    M_A | M_B | M_C | M_D | M_G,               // 3
    M_A | M_B | M_D | M_E | M_G,               // 2
    M_B | M_C,                                 // 1
    M_A | M_B | M_C | M_D | M_E | M_F          // 0
  };

  typedef enum logic [0:0] {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to active-high seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       hex_i,
  output logic [SEG_W-1:0] seg_c_o
);

  assign seg_c_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered display data,
// leading-zero suppression and inter-digit blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned BLANK_CYC      = 0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_hex,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   upd_blank,
  input  logic                    lz_en,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned HEX_W   = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX);
  localparam logic [SEG_W-1:0]      SEG_INV = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_INV  = AN_ACTIVE_LOW  ? '1 : '0;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    advance, wrap, accept, commit;

  logic [HEX_W-1:0]        pend_hex_q, act_hex_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_blank_q, act_dp_q, act_blank_q;
  logic                    pend_full_q, pend_full_d;
  logic                    ready_q, ready_d;
  logic                    frame_done_q;

  logic [3:0]              cur_hex;
  logic                    cur_dp, cur_blank, lz_zero, dark;
  logic [SEG_W-1:0]        dec_seg;
  logic [SEG_W-1:0]        seg_c, seg_q;
  logic                    dp_c, dp_q;
  logic [NUM_DIGITS-1:0]   an_c, an_q;

  // Slot sequencer: SHOW for CLK_DIV clocks, optional GAP, then next digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q + DIV_W'(1);
    advance = 1'b0;
    unique case (state_q)
      ST_SHOW: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (BLANK_CYC == 0) advance = 1'b1;
          else                state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (div_q == DIV_W'(BLANK_CYC - 1)) begin
          div_d   = '0;
          state_d = ST_SHOW;
          advance = 1'b1;
        end
      end
      default: state_d = ST_SHOW;
    endcase
    wrap = advance && (idx_q == IDX_W'(NUM_DIGITS - 1));
    if (advance) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
  end

  // Ready stays low through the commit clock so it reopens one clock after frame_done.
  always_comb begin
    accept      = upd_valid && ready_q;
    commit      = wrap && pend_full_q;
    pend_full_d = pend_full_q;
    if (commit) pend_full_d = 1'b0;
    if (accept) pend_full_d = 1'b1;
    ready_d = !pend_full_d && !commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SHOW;
      idx_q        <= '0;
      div_q        <= '0;
      pend_full_q  <= 1'b0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      pend_hex_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      act_hex_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      pend_full_q  <= pend_full_d;
      ready_q      <= ready_d;
      frame_done_q <= wrap;
      if (accept) begin
        pend_hex_q   <= upd_hex;
        pend_dp_q    <= upd_dp;
        pend_blank_q <= upd_blank;
      end
      if (commit) begin
        act_hex_q   <= pend_hex_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
      end
    end
  end

  // Current digit selection; lz_zero means this digit and all above it are zero.
  always_comb begin
    cur_hex   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    lz_zero   = 1'b1;
    an_c      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_hex   = act_hex_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = act_blank_q[i];
        an_c[i]   = (state_q == ST_SHOW);
      end
      if ((IDX_W'(i) >= idx_q) && (act_hex_q[4*i +: 4] != 4'h0)) lz_zero = 1'b0;
    end
    dark  = cur_blank || (lz_en && (idx_q != '0) && lz_zero);
    seg_c = ((state_q == ST_SHOW) && !dark) ? dec_seg : '0;
    dp_c  = (state_q == ST_SHOW) && !dark && cur_dp;
  end

  seg7_hex_decode u_dec (
    .hex_i   (cur_hex),
    .seg_c_o (dec_seg)
  );

  // Pin registers; polarity applied here only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_INV;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AN_INV;
    end else begin
      seg_q <= seg_c ^ SEG_INV;
      dp_q  <= dp_c ^ SEG_ACTIVE_LOW;
      an_q  <= an_c ^ AN_INV;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign upd_ready  = ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a normal-polarity and an inverted-polarity
// instance share stimulus and are checked against hand-computed values.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic [15:0] upd_hex;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_blank;
  logic        lz_en;

  logic        upd_ready, dp, frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_ready_n, dp_n, frame_done_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int f1, f2, f3;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_hex(upd_hex), .upd_dp(upd_dp), .upd_blank(upd_blank), .lz_en(lz_en),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready_n),
    .upd_hex(upd_hex), .upd_dp(upd_dp), .upd_blank(upd_blank), .lz_en(lz_en),
    .seg(seg_n), .dp(dp_n), .an(an_n), .frame_done(frame_done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance until frame_done is seen, bounded to two frames.
  task automatic wait_frame(input string tag, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = cyc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        seen   = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s frame_done timeout", tag);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    upd_valid = 1'b0;
    upd_hex   = 16'h0000;
    upd_dp    = 4'b0000;
    upd_blank = 4'b0000;
    lz_en     = 1'b0;
    #1 rst_n  = 1'b0;

    tick();
    check("rst_an",       32'(an), 32'h0);
    check("rst_seg",      32'(seg), 32'h0);
    check("rst_dp",       32'(dp), 32'h0);
    check("rst_ready",    32'(upd_ready), 32'h1);
    check("rst_fd",       32'(frame_done), 32'h0);
    check("rst_inv_an",   32'(an_n), 32'hF);
    check("rst_inv_seg",  32'(seg_n), 32'h7F);
    tick_n(2);
    rst_n = 1'b1;

    // First update, followed by a second request that must be ignored.
    upd_valid = 1'b1;
    upd_hex   = 16'h1234;
    tick();
    check("busy_ready", 32'(upd_ready), 32'h0);
    upd_hex = 16'hFFFF;
    tick();
    upd_valid = 1'b0;
    check("dark_seg", 32'(seg), 32'h0);
    check("dark_an",  32'(an), 32'h1);

    wait_frame("frame1", f1);
    check("commit_ready_low", 32'(upd_ready), 32'h0);
    check("commit_gap_an",    32'(an), 32'h0);
    tick();
    check("ready_back",  32'(upd_ready), 32'h1);
    check("fd_single",   32'(frame_done), 32'h0);
    check("d0_an",       32'(an), 32'h1);
    check("d0_seg4",     32'(seg), 32'h66);
    check("inv_d0_seg",  32'(seg_n), 32'h19);
    check("inv_d0_an",   32'(an_n), 32'hE);
    tick_n(3);
    check("d0_an_last",  32'(an), 32'h1);
    check("d0_seg_last", 32'(seg), 32'h66);
    tick();
    check("gap_an",      32'(an), 32'h0);
    check("inv_gap_an",  32'(an_n), 32'hF);
    tick();
    check("d1_an",       32'(an), 32'h2);
    check("d1_seg3",     32'(seg), 32'h4F);

    // Leading-zero suppression with a decimal point on digit 1.
    upd_valid = 1'b1;
    upd_hex   = 16'h0050;
    upd_dp    = 4'b0010;
    lz_en     = 1'b1;
    tick();
    upd_valid = 1'b0;
    check("acc2_ready", 32'(upd_ready), 32'h0);

    wait_frame("frame2", f2);
    check("period_a", 32'(f2 - f1), 32'd20);
    tick();
    check("lz_d0_an",  32'(an), 32'h1);
    check("lz_d0_seg", 32'(seg), 32'h3F);
    check("lz_d0_dp",  32'(dp), 32'h0);
    tick_n(5);
    check("lz_d1_an",  32'(an), 32'h2);
    check("lz_d1_seg", 32'(seg), 32'h6D);
    check("lz_d1_dp",  32'(dp), 32'h1);
    tick_n(5);
    check("lz_d2_an",  32'(an), 32'h4);
    check("lz_d2_seg", 32'(seg), 32'h0);
    tick_n(5);
    check("lz_d3_an",  32'(an), 32'h8);
    check("lz_d3_seg", 32'(seg), 32'h0);
    lz_en = 1'b0;
    tick();
    check("nolz_d3_seg", 32'(seg), 32'h3F);

    wait_frame("frame3", f3);
    check("period_b", 32'(f3 - f2), 32'd20);
    tick_n(11);
    check("nolz_d2_an",  32'(an), 32'h4);
    check("nolz_d2_seg", 32'(seg), 32'h3F);

    // Capture an update, then reset mid-SHOW before it commits.
    upd_valid = 1'b1;
    upd_hex   = 16'h8888;
    upd_dp    = 4'b0000;
    tick();
    upd_valid = 1'b0;
    check("pre_rst_ready", 32'(upd_ready), 32'h0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_an",    32'(an), 32'h0);
    check("mid_rst_seg",   32'(seg), 32'h0);
    check("mid_rst_ready", 32'(upd_ready), 32'h1);
    check("mid_rst_fd",    32'(frame_done), 32'h0);
    rst_n = 1'b1;
    wait_frame("frame4", f1);
    tick();
    check("lost_upd_an",  32'(an), 32'h1);
    check("lost_upd_seg", 32'(seg), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
